// File: rtl/uart_cmd_arbiter_if.sv
// uart_cmd_arbiter_if
//   Bundles the two requester channels and the uart command/read-return
//   channel that the arbiter sits between.
//
//   Requester channel N (N = 0, 1):
//     reqN_valid / reqN_data   command offered by requester N
//     reqN_ready               command accepted this cycle
//     rspN_valid               one-cycle completion pulse
//     rspN_data                read data (0 for writes and errors)
//     rspN_err                 timeout flag, qualified by rspN_valid
//   Uart channel:
//     cmd_valid / cmd_data     command towards the uart
//     cmd_ready                uart idle / accepting
//     read_valid / read_data   uart read-data pulse
//
//   Modports:
//     slave  - the arbiter's view (serves requesters, drives the uart)
//     master - the environment's view (requesters plus the uart)
interface uart_cmd_arbiter_if #(
  parameter int CMD_ADDR_WIDTH = 7,
  parameter int CMD_DATA_WIDTH = 8,
  parameter int CMD_RW_FLAG    = 1,
  parameter int CMD_WIDTH      = CMD_ADDR_WIDTH + CMD_DATA_WIDTH + CMD_RW_FLAG
);

  logic                      req0_valid;
  logic [CMD_WIDTH-1:0]      req0_data;
  logic                      req0_ready;
  logic                      rsp0_valid;
  logic [CMD_DATA_WIDTH-1:0] rsp0_data;
  logic                      rsp0_err;

  logic                      req1_valid;
  logic [CMD_WIDTH-1:0]      req1_data;
  logic                      req1_ready;
  logic                      rsp1_valid;
  logic [CMD_DATA_WIDTH-1:0] rsp1_data;
  logic                      rsp1_err;

  logic                      cmd_valid;
  logic [CMD_WIDTH-1:0]      cmd_data;
  logic                      cmd_ready;
  logic                      read_valid;
  logic [CMD_DATA_WIDTH-1:0] read_data;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  cmd_ready, read_valid, read_data,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    output cmd_valid, cmd_data
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output cmd_ready, read_valid, read_data,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    input  cmd_valid, cmd_data
  );

endinterface

// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter
//   Two-requester round-robin arbiter in front of a single uart command
//   port. A grant is held for the whole uart transaction: for a write
//   until the uart has gone busy and returned idle, for a read until the
//   read data pulse arrives. The completion is routed back to the owner
//   as a registered one-cycle rsp pulse.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    uart_cmd_arbiter_if.slave (requester channels + uart channel)
//
//   Optional feature macro: UART_ARB_TIMEOUT_EN
//     defined   - a wait-state counter aborts a hung WAIT_WR/WAIT_RD after
//                 TIMEOUT_CYCLES clocks with rspN_err = 1
//     undefined - no counter, waits are unbounded, rspN_err is tied to 0
module uart_cmd_arbiter #(
  parameter int CMD_ADDR_WIDTH = 7,
  parameter int CMD_DATA_WIDTH = 8,
  parameter int CMD_RW_FLAG    = 1,
  parameter int CMD_WIDTH      = CMD_ADDR_WIDTH + CMD_DATA_WIDTH + CMD_RW_FLAG,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_cmd_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_WR = 2'd2,
    WAIT_RD = 2'd3
  } state_t;

  state_t                    state;
  state_t                    next_state;

  logic                      cmd_valid_q;
  logic [CMD_WIDTH-1:0]      cmd_data_q;
  logic                      owner;
  logic                      last_grant;
  logic                      busy_seen;

  logic                      rsp0_valid_q;
  logic [CMD_DATA_WIDTH-1:0] rsp0_data_q;
  logic                      rsp1_valid_q;
  logic [CMD_DATA_WIDTH-1:0] rsp1_data_q;

  logic                      sel0;
  logic                      sel1;
  logic                      accept;
  logic                      complete;
  logic                      timed_out;
  logic [CMD_DATA_WIDTH-1:0] done_data;

  // last_grant = 1 means requester 1 held the most recent grant, so a tie
  // goes to requester 0 (this is also the reset value).
  always_comb begin
    sel0       = 1'b0;
    sel1       = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    next_state = state;

    case (state)
      IDLE: begin
        if (bus.req0_valid && (!bus.req1_valid || last_grant)) begin
          sel0 = 1'b1;
        end else if (bus.req1_valid) begin
          sel1 = 1'b1;
        end
        if (sel0 || sel1) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_valid_q && bus.cmd_ready) begin
          accept     = 1'b1;
          next_state = cmd_data_q[CMD_WIDTH-1] ? WAIT_WR : WAIT_RD;
        end
      end
      WAIT_WR: begin
        // The write is only done once the uart has been seen busy and
        // then idle again, i.e. the serial frame has actually gone out.
        if (bus.cmd_ready && busy_seen) begin
          complete = 1'b1;
        end
      end
      WAIT_RD: begin
        if (bus.read_valid) begin
          complete = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase

    if (complete || timed_out) begin
      next_state = IDLE;
    end
  end

  // Read data only travels back for a real read completion; writes and
  // timeouts report zero.
  assign done_data = (state == WAIT_RD && complete) ? bus.read_data
                                                    : '0;

  // The ready strobes are combinational but forced low while reset is held
  // so nothing looks accepted during reset.
  assign bus.req0_ready = rst_n & sel0;
  assign bus.req1_ready = rst_n & sel1;

  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_data   = cmd_data_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp1_data  = rsp1_data_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grant bookkeeping and the registered uart command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      busy_seen   <= 1'b0;
    end else begin
      if (sel0 || sel1) begin
        cmd_valid_q <= 1'b1;
        cmd_data_q  <= sel0 ? bus.req0_data : bus.req1_data;
        owner       <= sel1;
        last_grant  <= sel1;
      end
      if (accept) begin
        cmd_valid_q <= 1'b0;
        busy_seen   <= 1'b0;
      end else if (state == WAIT_WR && !bus.cmd_ready) begin
        busy_seen   <= 1'b1;
      end
    end
  end

  // Registered completion pulses; only the owner's port ever fires, so
  // both ports can never pulse together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      if (complete || timed_out) begin
        if (owner) begin
          rsp1_valid_q <= 1'b1;
          rsp1_data_q  <= done_data;
        end else begin
          rsp0_valid_q <= 1'b1;
          rsp0_data_q  <= done_data;
        end
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             rsp0_err_q;
  logic             rsp1_err_q;
  logic             in_wait;

  assign in_wait = (state == WAIT_WR) || (state == WAIT_RD);

  // The counter is zero in the first wait cycle, so firing on TMO_LAST
  // puts the error pulse exactly TIMEOUT_CYCLES cycles after entering the
  // wait state. A real completion in the same cycle takes precedence.
  assign timed_out = in_wait && !complete && (tmo_cnt == TMO_LAST);

  // Wait-state counter, restarted whenever a command is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (in_wait) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Error flags travel with the owner's rsp pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_err_q <= 1'b0;
      rsp1_err_q <= 1'b0;
    end else begin
      rsp0_err_q <= timed_out && !owner;
      rsp1_err_q <= timed_out && owner;
    end
  end

  assign bus.rsp0_err = rsp0_err_q;
  assign bus.rsp1_err = rsp1_err_q;
`else
  assign timed_out    = 1'b0;
  assign bus.rsp0_err = 1'b0;
  assign bus.rsp1_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// tb_uart_cmd_arbiter
//   Directed bench for uart_cmd_arbiter. The bench plays both requesters
//   and a minimal uart (cmd_ready busy/idle and read_valid pulses).
//   Build with or without UART_ARB_TIMEOUT_EN.
module tb_uart_cmd_arbiter;

  localparam int TIMEOUT_CYCLES = 20000;

  logic clk = 1'b0;
  logic rst_n;

  int checks    = 0;
  int failures  = 0;
  int rsp0_cnt  = 0;
  int rsp1_cnt  = 0;
  int both_cnt  = 0;
  int base0;
  int base1;
  int k;

  uart_cmd_arbiter_if bus ();

  uart_cmd_arbiter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counts completion pulses mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (bus.rsp0_valid) rsp0_cnt++;
    if (bus.rsp1_valid) rsp1_cnt++;
    if (bus.rsp0_valid && bus.rsp1_valid) both_cnt++;
  end

  // Hard stop in case something wedges the sequence below.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v0, input logic [15:0] d0,
                                input logic v1, input logic [15:0] d1);
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called right after the handshake edge: uart accepts, goes busy for a
  // few cycles, then returns idle. On return the rsp pulse is visible.
  task automatic serve_write();
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    repeat (3) tick();
    bus.cmd_ready = 1'b1;
    tick();
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.cmd_ready  = 1'b1;
    bus.read_valid = 1'b0;
    bus.read_data  = 8'h00;
    apply_stimulus(1'b1, 16'h8111, 1'b0, 16'h0000);
    repeat (3) tick();

    // Reset values, including ready held low despite a valid request.
    check_output("rst_cmd_valid",  32'(bus.cmd_valid),  32'd0);
    check_output("rst_cmd_data",   32'(bus.cmd_data),   32'd0);
    check_output("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check_output("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    check_output("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check_output("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    check_output("rst_rsp0_data",  32'(bus.rsp0_data),  32'd0);
    check_output("rst_rsp1_err",   32'(bus.rsp1_err),   32'd0);

    apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Contention straight after reset: req0 wins the first tie.
    apply_stimulus(1'b1, 16'h8111, 1'b1, 16'h8222);
    #1;
    check_output("tie1_req0_ready", 32'(bus.req0_ready), 32'd1);
    check_output("tie1_req1_ready", 32'(bus.req1_ready), 32'd0);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1, 16'h8222);
    check_output("tie1_cmd_data0", 32'(bus.cmd_data), 32'h8111);
    check_output("tie1_req1_wait", 32'(bus.req1_ready), 32'd0);
    serve_write();
    check_output("tie1_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    check_output("tie1_req1_ready", 32'(bus.req1_ready), 32'd1);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    check_output("tie1_cmd_data1", 32'(bus.cmd_data), 32'h8222);
    serve_write();
    check_output("tie1_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    tick();

    // Single write from req0 with cycle-exact timing.
    base0 = rsp0_cnt;
    base1 = rsp1_cnt;
    apply_stimulus(1'b1, 16'hE4AB, 1'b0, 16'h0000);
    #1;
    check_output("wr_req0_ready", 32'(bus.req0_ready), 32'd1);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    check_output("wr_cmd_valid", 32'(bus.cmd_valid), 32'd1);
    check_output("wr_cmd_data",  32'(bus.cmd_data),  32'hE4AB);
    tick();
    check_output("wr_cmd_valid_drop", 32'(bus.cmd_valid), 32'd0);
    bus.cmd_ready = 1'b0;
    repeat (4) tick();
    check_output("wr_no_early_rsp", 32'(rsp0_cnt - base0), 32'd0);
    bus.cmd_ready = 1'b1;
    tick();
    check_output("wr_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    check_output("wr_rsp0_err",   32'(bus.rsp0_err),   32'd0);
    check_output("wr_rsp0_data",  32'(bus.rsp0_data),  32'd0);
    tick();
    check_output("wr_rsp0_pulse_len", 32'(bus.rsp0_valid), 32'd0);
    check_output("wr_rsp0_count", 32'(rsp0_cnt - base0), 32'd1);
    check_output("wr_rsp1_count", 32'(rsp1_cnt - base1), 32'd0);

    // Stray read_valid in IDLE is ignored.
    base0 = rsp0_cnt;
    base1 = rsp1_cnt;
    bus.read_valid = 1'b1;
    bus.read_data  = 8'h55;
    tick();
    bus.read_valid = 1'b0;
    bus.read_data  = 8'h00;
    repeat (2) tick();
    check_output("stray_rsp0_count", 32'(rsp0_cnt - base0), 32'd0);
    check_output("stray_rsp1_count", 32'(rsp1_cnt - base1), 32'd0);

    // Last grant went to req0, so this tie goes to req1 first.
    apply_stimulus(1'b1, 16'h8333, 1'b1, 16'h8444);
    #1;
    check_output("tie2_req1_ready", 32'(bus.req1_ready), 32'd1);
    check_output("tie2_req0_ready", 32'(bus.req0_ready), 32'd0);
    tick();
    apply_stimulus(1'b1, 16'h8333, 1'b0, 16'h0000);
    check_output("tie2_cmd_data1", 32'(bus.cmd_data), 32'h8444);
    serve_write();
    check_output("tie2_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    check_output("tie2_req0_ready", 32'(bus.req0_ready), 32'd1);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    check_output("tie2_cmd_data0", 32'(bus.cmd_data), 32'h8333);
    serve_write();
    check_output("tie2_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    tick();

    // Single read from req1 returning 8'h35.
    apply_stimulus(1'b0, 16'h0000, 1'b1, 16'h6400);
    #1;
    check_output("rd_req1_ready", 32'(bus.req1_ready), 32'd1);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    check_output("rd_cmd_data", 32'(bus.cmd_data), 32'h6400);
    tick();
    bus.cmd_ready = 1'b0;
    repeat (5) tick();
    bus.read_valid = 1'b1;
    bus.read_data  = 8'h35;
    tick();
    bus.read_valid = 1'b0;
    bus.read_data  = 8'h00;
    check_output("rd_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    check_output("rd_rsp1_data",  32'(bus.rsp1_data),  32'h35);
    check_output("rd_rsp1_err",   32'(bus.rsp1_err),   32'd0);
    check_output("rd_rsp0_quiet", 32'(bus.rsp0_valid), 32'd0);
    bus.cmd_ready = 1'b1;
    tick();

    // Reset in the middle of a read drops it without a response.
    apply_stimulus(1'b0, 16'h0000, 1'b1, 16'h6400);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    tick();
    bus.cmd_ready = 1'b0;
    repeat (2) tick();
    base0 = rsp0_cnt;
    base1 = rsp1_cnt;
    rst_n = 1'b0;
    #1;
    check_output("mrst_cmd_valid",  32'(bus.cmd_valid),  32'd0);
    check_output("mrst_cmd_data",   32'(bus.cmd_data),   32'd0);
    check_output("mrst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.read_valid = 1'b1;
    bus.read_data  = 8'h35;
    tick();
    bus.read_valid = 1'b0;
    bus.read_data  = 8'h00;
    repeat (3) tick();
    check_output("mrst_no_rsp1", 32'(rsp1_cnt - base1), 32'd0);
    check_output("mrst_no_rsp0", 32'(rsp0_cnt - base0), 32'd0);
    bus.cmd_ready = 1'b1;
    apply_stimulus(1'b0, 16'h0000, 1'b1, 16'h6400);
    #1;
    check_output("mrst_req1_ready", 32'(bus.req1_ready), 32'd1);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    tick();
    bus.cmd_ready = 1'b0;
    repeat (3) tick();
    bus.read_valid = 1'b1;
    bus.read_data  = 8'h35;
    tick();
    bus.read_valid = 1'b0;
    bus.read_data  = 8'h00;
    check_output("mrst_rd_valid", 32'(bus.rsp1_valid), 32'd1);
    check_output("mrst_rd_data",  32'(bus.rsp1_data),  32'h35);
    bus.cmd_ready = 1'b1;
    tick();

    // Hung read from req0 with no read_valid ever arriving.
    base0 = rsp0_cnt;
    apply_stimulus(1'b1, 16'h6400, 1'b0, 16'h0000);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    tick();
`ifdef UART_ARB_TIMEOUT_EN
    k = 0;
    while (k < TIMEOUT_CYCLES + 10 && !bus.rsp0_valid) begin
      tick();
      k++;
    end
    check_output("tmo_cycles",     32'(k),              32'(TIMEOUT_CYCLES));
    check_output("tmo_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    check_output("tmo_rsp0_err",   32'(bus.rsp0_err),   32'd1);
    check_output("tmo_rsp0_data",  32'(bus.rsp0_data),  32'd0);
    apply_stimulus(1'b0, 16'h0000, 1'b1, 16'h8555);
    #1;
    check_output("tmo_next_ready", 32'(bus.req1_ready), 32'd1);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    check_output("tmo_next_cmd", 32'(bus.cmd_data), 32'h8555);
`else
    repeat (3 * TIMEOUT_CYCLES) tick();
    check_output("notmo_no_rsp0", 32'(rsp0_cnt - base0), 32'd0);
`endif

    check_output("never_both_rsp", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
